// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin SPI mode-0 ADC scan sequencer
// Ticks a slot timer, picks the next enabled channel, shifts one frame and emits a sample beat.
module adc_scan_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int CH_ID_WIDTH   = 4,
  parameter int NUM_CH        = 16,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 256
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst_n,
  input  logic                   scan_en,
  input  logic [NUM_CH-1:0]      ch_mask,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  output logic                   adc_mosi,
  input  logic                   adc_miso,
  output logic [DATA_WIDTH-1:0]  adc_data_out,
  output logic [CH_ID_WIDTH-1:0] adc_channel_out,
  output logic                   adc_valid_out,
  output logic                   scan_busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int TW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DVW = $clog2(SCLK_DIV + 1);
  localparam int BW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               rst_sync_q;
  logic                     rst_n;
  logic [TW-1:0]            timer_q;
  logic [DVW-1:0]           div_q;
  logic [BW-1:0]            bit_q;
  logic [NUM_CH-1:0]        mask_q;
  logic [CH_ID_WIDTH-1:0]   ptr_q, ch_q, mosi_sr_q, ch_out_q;
  logic [DATA_WIDTH-1:0]    sh_q, data_q;
  logic                     tick, div_last, bit_last, nxt_found;
  logic [CH_ID_WIDTH-1:0]   nxt_ch, hi_ch;
  int                       idx;

  // Assertion is asynchronous; release is aligned to sensor_clk.
  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) rst_sync_q <= 2'b00;
    else               rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign tick     = scan_en && (timer_q == TW'(SAMPLE_PERIOD - 1));
  assign div_last = (div_q == DVW'(SCLK_DIV - 1));
  assign bit_last = (bit_q == BW'(DATA_WIDTH - 1));

  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (!nxt_found && ch_mask[idx]) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    hi_ch = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mask_q[i]) hi_ch = CH_ID_WIDTH'(i);
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (tick && nxt_found) state_d = S_SETUP;
      S_SETUP:    if (div_last) state_d = S_SHIFT_HI;
      S_SHIFT_HI: if (div_last) state_d = S_SHIFT_LO;
      S_SHIFT_LO: if (div_last) state_d = bit_last ? S_DONE : S_SHIFT_HI;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= TW'(SAMPLE_PERIOD - 1);
      div_q     <= '0;
      bit_q     <= '0;
      mask_q    <= '0;
      ptr_q     <= CH_ID_WIDTH'(NUM_CH - 1);
      ch_q      <= '0;
      mosi_sr_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      ch_out_q  <= '0;
    end else begin
      if (!scan_en)     timer_q <= TW'(SAMPLE_PERIOD - 1);
      else if (tick)    timer_q <= '0;
      else              timer_q <= timer_q + 1'b1;

      if (state_q == S_IDLE || state_d != state_q) div_q <= '0;
      else                                         div_q <= div_q + 1'b1;

      if (state_q == S_IDLE)                      bit_q <= '0;
      else if (state_q == S_SHIFT_LO && div_last) bit_q <= bit_q + 1'b1;

      // Slot ticks outside IDLE are dropped, so the mask is only sampled here.
      if (state_q == S_IDLE && tick) begin
        mask_q <= ch_mask;
        if (nxt_found) begin
          ch_q      <= nxt_ch;
          mosi_sr_q <= nxt_ch;
        end
      end

      if (state_q == S_SHIFT_HI && div_q == '0)
        sh_q <= {sh_q[DATA_WIDTH-2:0], adc_miso};
      if (state_q == S_SHIFT_HI && div_last)
        mosi_sr_q <= {mosi_sr_q[CH_ID_WIDTH-2:0], 1'b0};

      if (state_q == S_SHIFT_LO && div_last && bit_last) begin
        data_q   <= sh_q;
        ch_out_q <= ch_q;
      end

      if (state_q == S_DONE) ptr_q <= ch_q;
    end
  end

  always_comb begin
    adc_cs_n        = 1'b1;
    adc_sclk        = 1'b0;
    adc_mosi        = 1'b0;
    adc_valid_out   = 1'b0;
    frame_done      = 1'b0;
    scan_busy       = (state_q != S_IDLE);
    overrun         = tick && (state_q != S_IDLE);
    adc_data_out    = data_q;
    adc_channel_out = ch_out_q;
    case (state_q)
      S_SETUP, S_SHIFT_LO: begin
        adc_cs_n = 1'b0;
        adc_mosi = mosi_sr_q[CH_ID_WIDTH-1];
      end
      S_SHIFT_HI: begin
        adc_cs_n = 1'b0;
        adc_sclk = 1'b1;
        adc_mosi = mosi_sr_q[CH_ID_WIDTH-1];
      end
      S_DONE: begin
        adc_valid_out = 1'b1;
        frame_done    = (ch_q == hi_ch);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed bench for adc_scan_sequencer
// Behavioural ADC slave, hand-computed cycle expectations, one check task.
module tb_adc_scan_sequencer;

  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int NCH = 16;

  logic           sensor_clk = 1'b0;
  logic           sensor_rst_n = 1'b0;
  logic           scan_en, scan_en2;
  logic [NCH-1:0] ch_mask;
  logic           adc_cs_n, adc_sclk, adc_mosi;
  logic           adc_miso = 1'b0;
  logic [DW-1:0]  adc_data_out;
  logic [CW-1:0]  adc_channel_out;
  logic           adc_valid_out, scan_busy, frame_done, overrun;
  logic           cs_n2, sclk2, mosi2, valid2, busy2, fd2, ovr2;
  logic [DW-1:0]  data2;
  logic [CW-1:0]  ch2;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]  adc_word = '0;
  logic [DW-1:0]  mosi_cap = '0;
  int             adc_idx = 0;
  logic           cs_prev = 1'b1;
  logic           sclk_prev = 1'b0;

  always #5 sensor_clk = ~sensor_clk;

  adc_scan_sequencer dut (
    .sensor_clk(sensor_clk), .sensor_rst_n(sensor_rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
    .adc_data_out(adc_data_out), .adc_channel_out(adc_channel_out), .adc_valid_out(adc_valid_out),
    .scan_busy(scan_busy), .frame_done(frame_done), .overrun(overrun)
  );

  adc_scan_sequencer #(.SAMPLE_PERIOD(100)) dut2 (
    .sensor_clk(sensor_clk), .sensor_rst_n(sensor_rst_n), .scan_en(scan_en2), .ch_mask(16'h0001),
    .adc_cs_n(cs_n2), .adc_sclk(sclk2), .adc_mosi(mosi2), .adc_miso(1'b1),
    .adc_data_out(data2), .adc_channel_out(ch2), .adc_valid_out(valid2),
    .scan_busy(busy2), .frame_done(fd2), .overrun(ovr2)
  );

  // ADC slave: MSB out on cs_n fall, next bit after each sclk fall; mosi captured on sclk rise.
  always @(negedge sensor_clk) begin
    if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
      adc_idx  = DW - 1;
      mosi_cap = '0;
    end else if (sclk_prev === 1'b1 && adc_sclk === 1'b0 && adc_cs_n === 1'b0 && adc_idx > 0) begin
      adc_idx = adc_idx - 1;
    end
    if (sclk_prev === 1'b0 && adc_sclk === 1'b1)
      mosi_cap = {mosi_cap[DW-2:0], adc_mosi};
    adc_miso  = adc_word[adc_idx];
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge sensor_clk);
  endtask

  initial begin
    int exp_ch [4] = '{5, 10, 15, 0};
    int exp_fd [4] = '{0, 0, 1, 0};
    int cs_lows, valids, ovrs;

    scan_en = 1'b0; scan_en2 = 1'b0; ch_mask = '0;
    adv(3);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_mosi", adc_mosi, 0);
    check("rst_data", adc_data_out, 0);
    check("rst_ch", adc_channel_out, 0);
    check("rst_valid", adc_valid_out, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovr", overrun, 0);
    sensor_rst_n = 1'b1;
    adv(4);

    // Single channel, first tick is cycle 0.
    adc_word = 16'hA5C3; ch_mask = 16'h0001; scan_en = 1'b1;
    check("t1_c0_cs_n", adc_cs_n, 1);
    check("t1_c0_ovr", overrun, 0);
    adv(1);
    check("t1_c1_cs_n", adc_cs_n, 0);
    check("t1_c1_busy", scan_busy, 1);
    check("t1_c1_sclk", adc_sclk, 0);
    adv(4);
    check("t1_c5_sclk", adc_sclk, 1);
    adv(127);
    check("t1_c132_valid", adc_valid_out, 0);
    adv(1);
    check("t1_c133_valid", adc_valid_out, 1);
    check("t1_c133_data", adc_data_out, 16'hA5C3);
    check("t1_c133_ch", adc_channel_out, 0);
    check("t1_c133_fd", frame_done, 1);
    check("t1_c133_busy", scan_busy, 1);
    check("t1_c133_cs_n", adc_cs_n, 1);
    adv(1);
    check("t1_c134_busy", scan_busy, 0);
    check("t1_c134_valid", adc_valid_out, 0);
    adv(255);
    check("t1_c389_valid", adc_valid_out, 1);
    check("t1_c389_data", adc_data_out, 16'hA5C3);

    // Round-robin over 0x8421.
    adc_word = 16'h1234; ch_mask = 16'h8421;
    for (int k = 0; k < 4; k++) begin
      adv(256);
      check("t2_valid", adc_valid_out, 1);
      check("t2_ch", adc_channel_out, exp_ch[k]);
      check("t2_fd", frame_done, exp_fd[k]);
      check("t2_data", adc_data_out, 16'h1234);
      check("t2_mosi", mosi_cap, {exp_ch[k][3:0], 12'h000});
    end

    // Empty mask: no activity at all.
    ch_mask = '0;
    cs_lows = 0; valids = 0; ovrs = 0;
    for (int k = 0; k < 1000; k++) begin
      adv(1);
      if (adc_cs_n !== 1'b1) cs_lows++;
      if (adc_valid_out !== 1'b0) valids++;
      if (overrun !== 1'b0) ovrs++;
    end
    check("t3_cs_lows", cs_lows, 0);
    check("t3_valids", valids, 0);
    check("t3_ovrs", ovrs, 0);

    // scan_en drop mid-frame, pointer retained across re-enable.
    scan_en = 1'b0; adv(2);
    ch_mask = 16'h0006; scan_en = 1'b1;
    adv(50);
    scan_en = 1'b0;
    adv(83);
    check("t6_valid", adc_valid_out, 1);
    check("t6_ch", adc_channel_out, 1);
    check("t6_fd", frame_done, 0);
    cs_lows = 0; valids = 0;
    for (int k = 0; k < 300; k++) begin
      adv(1);
      if (adc_cs_n !== 1'b1) cs_lows++;
      if (adc_valid_out !== 1'b0) valids++;
    end
    check("t6_idle_cs_lows", cs_lows, 0);
    check("t6_idle_valids", valids, 0);
    scan_en = 1'b1;
    adv(133);
    check("t6_re_valid", adc_valid_out, 1);
    check("t6_re_ch", adc_channel_out, 2);
    check("t6_re_fd", frame_done, 1);

    // Reset mid-shift aborts the frame and restarts the pointer.
    scan_en = 1'b0; adv(2);
    ch_mask = 16'h0009; scan_en = 1'b1;
    adv(60);
    check("t5_c60_sclk_active", adc_cs_n, 0);
    sensor_rst_n = 1'b0; scan_en = 1'b0;
    #1;
    check("t5_rst_cs_n", adc_cs_n, 1);
    check("t5_rst_sclk", adc_sclk, 0);
    check("t5_rst_busy", scan_busy, 0);
    check("t5_rst_data", adc_data_out, 0);
    valids = 0;
    for (int k = 0; k < 3; k++) begin
      adv(1);
      if (adc_valid_out !== 1'b0) valids++;
    end
    sensor_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adv(1);
      if (adc_valid_out !== 1'b0) valids++;
    end
    scan_en = 1'b1;
    for (int k = 0; k < 132; k++) begin
      adv(1);
      if (adc_valid_out !== 1'b0) valids++;
    end
    check("t5_no_early_valid", valids, 0);
    adv(1);
    check("t5_valid", adc_valid_out, 1);
    check("t5_ch", adc_channel_out, 0);
    check("t5_fd", frame_done, 0);
    check("t5_data", adc_data_out, 16'h1234);

    // Short slot period: overrun inside each frame, one valid per 200 cycles.
    scan_en2 = 1'b1;
    for (int k = 0; k < 400; k++) begin
      check("t4_ovr", ovr2, (k % 200) == 100);
      check("t4_valid", valid2, (k % 200) == 133);
      if (k == 133) begin
        check("t4_data", data2, 16'hFFFF);
        check("t4_ch", ch2, 0);
        check("t4_fd", fd2, 1);
        check("t4_cs_n", cs_n2, 1);
        check("t4_busy", busy2, 1);
        check("t4_sclk", sclk2, 0);
        check("t4_mosi", mosi2, 0);
      end
      adv(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
